slip_axis_decoder: RTL

SLIP_AXIS_DECODER -- requirements
Module: slip_axis_decoder

---
 rtl/slip_pkg.sv | 23 ++
 rtl/slip_axis_decoder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/slip_pkg.sv
// SLIP byte constants, decoder state type and unescape helper.
// Shared by the decoder RTL and its bench.
package slip_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {
    SM_IDLE    = 2'd0,
    SM_DATA    = 2'd1,
    SM_ESC     = 2'd2,
    SM_DISCARD = 2'd3
  } slip_sm_t;

  function automatic logic [7:0] slip_unesc(
    input logic [7:0] b
  );
    return (b == SLIP_ESC_END) ? SLIP_END : SLIP_ESC;
  endfunction

endpackage

// File: rtl/slip_axis_decoder.sv
// SLIP-to-AXI-Stream frame decoder with one-byte hold and registered output.
// Define SLIP_DECODER_STATS_EN to add saturating frame_cnt/err_cnt outputs.
module slip_axis_decoder
  import slip_pkg::*;
#(
  parameter int STAT_BITS = 16
) (
  input  logic       clk,
  input  logic       aresetn,
  output logic       axis_i_tready,
  input  logic       axis_i_tvalid,
  input  logic [7:0] axis_i_tdata,
  input  logic       axis_o_tready,
  output logic       axis_o_tvalid,
  output logic       axis_o_tlast,
  output logic [7:0] axis_o_tdata,
  output logic       err_o
`ifdef SLIP_DECODER_STATS_EN
  ,
  output logic [STAT_BITS-1:0] frame_cnt,
  output logic [STAT_BITS-1:0] err_cnt
`endif
);

  if (STAT_BITS < 1) begin : g_bad_stat_bits
  end

  slip_sm_t   st, st_n;
  logic [7:0] hold, hold_n;
  logic       hv, hv_n;
  logic       emit, emit_last, err_n;
  logic       acc, is_end, is_esc, is_unesc;

  assign axis_i_tready = !axis_o_tvalid || axis_o_tready;
  assign acc      = axis_i_tvalid && axis_i_tready;
  assign is_end   = axis_i_tdata == SLIP_END;
  assign is_esc   = axis_i_tdata == SLIP_ESC;
  assign is_unesc = (axis_i_tdata == SLIP_ESC_END) ||
                    (axis_i_tdata == SLIP_ESC_ESC);

  always_comb begin
    st_n      = st;
    hold_n    = hold;
    hv_n      = hv;
    emit      = 1'b0;
    emit_last = 1'b0;
    err_n     = 1'b0;
    if (acc) begin
      case (st)
        SM_IDLE: begin
          unique case (1'b1)
            is_end: ;
            is_esc: st_n = SM_ESC;
            default: begin
              hold_n = axis_i_tdata;
              hv_n   = 1'b1;
              st_n   = SM_DATA;
            end
          endcase
        end
        SM_DATA: begin
          unique case (1'b1)
            is_end: begin
              emit      = 1'b1;
              emit_last = 1'b1;
              hv_n      = 1'b0;
              st_n      = SM_IDLE;
            end
            is_esc: st_n = SM_ESC;
            default: begin
              emit   = 1'b1;
              hold_n = axis_i_tdata;
            end
          endcase
        end
        SM_ESC: begin
          if (is_unesc) begin
            emit   = hv;
            hold_n = slip_unesc(axis_i_tdata);
            hv_n   = 1'b1;
            st_n   = SM_DATA;
          end else begin
            // bad escape closes any partial frame
            err_n     = 1'b1;
            emit      = hv;
            emit_last = 1'b1;
            hv_n      = 1'b0;
            st_n      = is_end ? SM_IDLE : SM_DISCARD;
          end
        end
        default: begin
          if (is_end) st_n = SM_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      st            <= SM_IDLE;
      hold          <= '0;
      hv            <= 1'b0;
      axis_o_tvalid <= 1'b0;
      axis_o_tlast  <= 1'b0;
      axis_o_tdata  <= '0;
      err_o         <= 1'b0;
    end else begin
      st    <= st_n;
      hold  <= hold_n;
      hv    <= hv_n;
      err_o <= err_n;
      if (emit) begin
        axis_o_tvalid <= 1'b1;
        axis_o_tdata  <= hold;
        axis_o_tlast  <= emit_last;
      end else if (axis_o_tready) begin
        axis_o_tvalid <= 1'b0;
      end
    end
  end

`ifdef SLIP_DECODER_STATS_EN
  logic fr_inc;
  assign fr_inc = axis_o_tvalid && axis_o_tready &&
                  axis_o_tlast;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (fr_inc && (frame_cnt != '1))
        frame_cnt <= frame_cnt + 1'b1;
      if (err_n && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
